fetch_seq_ctrl: RTL and testbench

//  Multicycle fetch/decode sequencer for the LC-3b datapath. Drives MAR/PC/MDR/IR load strobes

---
 rtl/fetch_seq_ctrl.sv | 110 +++++++++++
 tb/tb_fetch_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// Multicycle fetch/decode sequencer: strobes MAR/PC/MDR/IR through a handshaked memory read,
// hands the instruction to execute, detects the BRnzp #-1 halt idiom and fetch timeouts.
module fetch_seq_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      ir_data,
  input  logic             mem_resp,
  input  logic             exec_done,
  output logic             load_mar,
  output logic             load_pc,
  output logic             mem_read,
  output logic             load_mdr,
  output logic             load_ir,
  output logic             ir_valid,
  output logic             busy,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [15:0] HALT_IDIOM = 16'h0FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      retired_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (retire) retired_count <= sat_inc(retired_count);
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    retire       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH1;
      S_FETCH1: begin
        wait_cnt_nxt = '0;
        state_nxt    = S_FETCH2;
      end
      S_FETCH2: begin
        // a response arriving on the last allowed cycle still completes the fetch
        if (mem_resp)
          state_nxt = S_FETCH3;
        else if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST))
          state_nxt = S_ERROR;
        else
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
      end
      S_FETCH3: state_nxt = S_DECODE;
      S_DECODE: begin
        if (ir_data == HALT_IDIOM) begin
          state_nxt = S_HALT;
          retire    = 1'b1;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_nxt = S_FETCH1;
          retire    = 1'b1;
        end
      end
      S_HALT:   state_nxt = S_HALT;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign load_mar = (state == S_FETCH1);
  assign load_pc  = (state == S_FETCH1);
  assign mem_read = (state == S_FETCH2);
  assign load_mdr = (state == S_FETCH2) && mem_resp;
  assign load_ir  = (state == S_FETCH3);
  assign ir_valid = (state == S_EXEC);
  assign busy     = (state != S_IDLE) && (state != S_HALT) && (state != S_ERROR);
  assign halted   = (state == S_HALT);
  assign mem_err  = (state == S_ERROR);

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl (CNT_W=4, MEM_TIMEOUT=4) with a queue scoreboard of
// per-cycle expected strobe/status/count vectors.
module tb_fetch_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] ir_data;
  logic        mem_resp;
  logic        exec_done;
  logic        load_mar, load_pc, mem_read, load_mdr, load_ir;
  logic        ir_valid, busy, halted, mem_err;
  logic [3:0]  retired_count;

  int checks;
  int errors;

  logic [12:0] sb_q[$];
  string       tag_q[$];

  // expected {mar, pc, read, mdr, ir, ir_valid, busy, halted, mem_err}
  localparam logic [8:0] E_IDLE = 9'b000000000;
  localparam logic [8:0] E_F1   = 9'b110000100;
  localparam logic [8:0] E_F2   = 9'b001000100;
  localparam logic [8:0] E_F2R  = 9'b001100100;
  localparam logic [8:0] E_F3   = 9'b000010100;
  localparam logic [8:0] E_DEC  = 9'b000000100;
  localparam logic [8:0] E_EX   = 9'b000001100;
  localparam logic [8:0] E_HALT = 9'b000000010;
  localparam logic [8:0] E_ERR  = 9'b000000001;

  fetch_seq_ctrl #(
    .CNT_W      (4),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ir_data      (ir_data),
    .mem_resp     (mem_resp),
    .exec_done    (exec_done),
    .load_mar     (load_mar),
    .load_pc      (load_pc),
    .mem_read     (mem_read),
    .load_mdr     (load_mdr),
    .load_ir      (load_ir),
    .ir_valid     (ir_valid),
    .busy         (busy),
    .halted       (halted),
    .mem_err      (mem_err),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge with inputs already applied; checks this cycle, then advances one cycle.
  task automatic step(input string tag, input logic [8:0] st, input logic [3:0] cnt);
    logic [12:0] obs;
    logic [12:0] exp;
    string       t;
    sb_q.push_back({st, cnt});
    tag_q.push_back(tag);
    #1;
    obs = {load_mar, load_pc, mem_read, load_mdr, load_ir, ir_valid, busy, halted, mem_err,
           retired_count};
    exp = sb_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    mem_resp  = 1'b0;
    exec_done = 1'b0;
    ir_data   = 16'h0000;
    @(negedge clk);
    step("rst_hold", E_IDLE, 4'd0);
    rst_n = 1'b1;
    step("idle", E_IDLE, 4'd0);

    // basic fetch/execute
    start = 1'b1;   step("t1_idle", E_IDLE, 4'd0);
    start = 1'b0;   step("t1_f1", E_F1, 4'd0);
    mem_resp = 1'b1; step("t1_f2", E_F2R, 4'd0);
    mem_resp = 1'b0; ir_data = 16'h1042;
    step("t1_f3", E_F3, 4'd0);
    step("t1_dec", E_DEC, 4'd0);
    step("t1_ex0", E_EX, 4'd0);
    step("t1_ex1", E_EX, 4'd0);
    exec_done = 1'b1; step("t1_ex2", E_EX, 4'd0);
    exec_done = 1'b0; step("t1_f1b", E_F1, 4'd1);

    // stray exec_done in FETCH2, response on the last allowed cycle, stray start in EXEC
    exec_done = 1'b1; step("t5_f2a", E_F2, 4'd1);
    exec_done = 1'b0; step("t5_f2b", E_F2, 4'd1);
    step("t5_f2c", E_F2, 4'd1);
    mem_resp = 1'b1; step("t2_f2d_resp", E_F2R, 4'd1);
    mem_resp = 1'b0; step("t2_f3", E_F3, 4'd1);
    step("t5_dec", E_DEC, 4'd1);
    start = 1'b1;   step("t5_ex_start", E_EX, 4'd1);
    start = 1'b0;   step("t5_ex", E_EX, 4'd1);
    exec_done = 1'b1; step("t5_ex_done", E_EX, 4'd1);
    exec_done = 1'b0; step("t5_f1", E_F1, 4'd2);

    // timeout: four FETCH2 cycles then sticky error
    step("t2_to0", E_F2, 4'd2);
    step("t2_to1", E_F2, 4'd2);
    step("t2_to2", E_F2, 4'd2);
    step("t2_to3", E_F2, 4'd2);
    step("t2_err0", E_ERR, 4'd2);
    start = 1'b1; mem_resp = 1'b1; exec_done = 1'b1;
    step("t2_err_sticky", E_ERR, 4'd2);
    start = 1'b0; mem_resp = 1'b0; exec_done = 1'b0;
    step("t2_err_sticky2", E_ERR, 4'd2);

    // asynchronous reset out of ERROR, then in FETCH2, then in EXEC
    rst_n = 1'b0;   step("t4_rst_err", E_IDLE, 4'd0);
    rst_n = 1'b1;   step("t4_idle0", E_IDLE, 4'd0);
    start = 1'b1;   step("t4_idle1", E_IDLE, 4'd0);
    start = 1'b0;   step("t4_f1", E_F1, 4'd0);
    step("t4_f2", E_F2, 4'd0);
    rst_n = 1'b0;   step("t4_rst_f2", E_IDLE, 4'd0);
    rst_n = 1'b1;   step("t4_no_resume", E_IDLE, 4'd0);
    start = 1'b1;   step("t4_idle2", E_IDLE, 4'd0);
    start = 1'b0;   step("t4_f1b", E_F1, 4'd0);
    mem_resp = 1'b1; step("t4_f2b", E_F2R, 4'd0);
    mem_resp = 1'b0; step("t4_f3b", E_F3, 4'd0);
    step("t4_decb", E_DEC, 4'd0);
    exec_done = 1'b1; step("t4_exb", E_EX, 4'd0);
    exec_done = 1'b0; step("t4_f1c", E_F1, 4'd1);
    mem_resp = 1'b1; step("t4_f2c", E_F2R, 4'd1);
    mem_resp = 1'b0; step("t4_f3c", E_F3, 4'd1);
    step("t4_decc", E_DEC, 4'd1);
    step("t4_exc", E_EX, 4'd1);
    rst_n = 1'b0;   step("t4_rst_ex", E_IDLE, 4'd0);
    rst_n = 1'b1;   step("t4_idle3", E_IDLE, 4'd0);

    // halt idiom
    start = 1'b1;   step("t3_idle", E_IDLE, 4'd0);
    start = 1'b0;   step("t3_f1", E_F1, 4'd0);
    mem_resp = 1'b1; step("t3_f2", E_F2R, 4'd0);
    mem_resp = 1'b0; ir_data = 16'h0FFF;
    step("t3_f3", E_F3, 4'd0);
    step("t3_dec", E_DEC, 4'd0);
    step("t3_halt", E_HALT, 4'd1);
    start = 1'b1; exec_done = 1'b1; mem_resp = 1'b1;
    step("t3_halt_sticky", E_HALT, 4'd1);
    start = 1'b0; exec_done = 1'b0; mem_resp = 1'b0;
    step("t3_halt_sticky2", E_HALT, 4'd1);

    // saturation: 17 retirements on a 4-bit counter
    rst_n = 1'b0;   step("t5_rst", E_IDLE, 4'd0);
    rst_n = 1'b1;   start = 1'b1;
    step("t5_sat_idle", E_IDLE, 4'd0);
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      logic [3:0] pre;
      pre = (i > 15) ? 4'hF : 4'(i);
      ir_data = 16'h1042 + 16'(i);
      step("sat_f1", E_F1, pre);
      mem_resp = 1'b1;  step("sat_f2", E_F2R, pre);
      mem_resp = 1'b0;  step("sat_f3", E_F3, pre);
      step("sat_dec", E_DEC, pre);
      exec_done = 1'b1; step("sat_ex", E_EX, pre);
      exec_done = 1'b0;
    end
    step("sat_final", E_F1, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
